ws2811_transmitter: RTL and testbench

WS2811_TRANSMITTER -- requirements
Module: ws2811_transmitter

---
 rtl/ws2811_pkg.sv | 18 +
 rtl/ws2811_bit_encoder.sv | 43 ++++
 rtl/ws2811_transmitter.sv | 130 +++++++++++++
 tb/tb_ws2811_transmitter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ws2811_pkg.sv
// Shared FSM state type and default timing for the WS2811 serial transmitter.
package ws2811_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    LATCH
  } state_t;

  localparam int DEF_NUM_LEDS        = 50;
  localparam int DEF_BIT_CYCLES      = 63;
  localparam int DEF_T0H_CYCLES      = 20;
  localparam int DEF_T1H_CYCLES      = 40;
  localparam int DEF_RESET_CYCLES    = 2750;
  localparam int DEF_PREFETCH_CYCLES = 32;

endpackage

// File: rtl/ws2811_bit_encoder.sv
// Shapes one WS2811 bit: dout high for T0H/T1H cycles, low until BIT_CYCLES; bit_done on the last cycle.
// A start on the bit_done cycle chains the next bit with no gap; no backpressure.
module ws2811_bit_encoder #(
  parameter int BIT_CYCLES = 63,
  parameter int T0H_CYCLES = 20,
  parameter int T1H_CYCLES = 40
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_val,
  output logic dout,
  output logic bit_done
);

  localparam int W = $clog2(BIT_CYCLES + 1);

  logic         active;
  logic         val;
  logic [W-1:0] cnt;

  assign bit_done = active && (cnt == W'(BIT_CYCLES - 1));
  // Decoded from flops so an async reset drops the line immediately, mid-bit included.
  assign dout     = active && (cnt < (val ? W'(T1H_CYCLES) : W'(T0H_CYCLES)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      val    <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      val    <= bit_val;
      cnt    <= '0;
    end else if (bit_done) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (active) begin
      cnt    <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/ws2811_transmitter.sv
// WS2811 frame transmitter: prefetch, NUM_LEDS x 24 bits, then a low latch gap. Colour
// order is RGB, or GRB when WS2811_GRB_EN is defined. enable is only looked at in IDLE and at latch exit.
module ws2811_transmitter
  import ws2811_pkg::*;
#(
  parameter int NUM_LEDS        = DEF_NUM_LEDS,
  parameter int BIT_CYCLES      = DEF_BIT_CYCLES,
  parameter int T0H_CYCLES      = DEF_T0H_CYCLES,
  parameter int T1H_CYCLES      = DEF_T1H_CYCLES,
  parameter int RESET_CYCLES    = DEF_RESET_CYCLES,
  parameter int PREFETCH_CYCLES = DEF_PREFETCH_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  output logic [7:0] ledindex,
  output logic       dout,
  output logic       busy,
  output logic       frame_done
);

  localparam int MAXC = (RESET_CYCLES > PREFETCH_CYCLES) ? RESET_CYCLES : PREFETCH_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  if (!(T0H_CYCLES > 0 && T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_CYCLES)) begin : g_bad_bit_timing
    $error("ws2811_transmitter: need 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES");
  end
  if (!(24 * BIT_CYCLES >= PREFETCH_CYCLES && PREFETCH_CYCLES >= 1)) begin : g_bad_prefetch
    $error("ws2811_transmitter: need 1 <= PREFETCH_CYCLES <= 24*BIT_CYCLES");
  end
  if (!(NUM_LEDS >= 1 && NUM_LEDS <= 256 && RESET_CYCLES >= 1)) begin : g_bad_frame
    $error("ws2811_transmitter: need 1 <= NUM_LEDS <= 256 and RESET_CYCLES >= 1");
  end

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [4:0]    bit_idx;
  logic [7:0]    pix, nxt_pix;
  logic [23:0]   sr, word;
  logic          enc_start, enc_bit, pix_start, bit_done;

`ifdef WS2811_GRB_EN
  assign word = {green, red, blue};
`else
  assign word = {red, green, blue};
`endif

  assign nxt_pix    = (state == LOAD) ? 8'd0 : pix + 8'd1;
  assign busy       = (state != IDLE);
  assign frame_done = (state == LATCH) && (cnt == CW'(RESET_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    enc_start = 1'b0;
    enc_bit   = sr[23];
    pix_start = 1'b0;
    case (state)
      IDLE:  if (enable) state_nxt = LOAD;
      LOAD: begin
        if (cnt == CW'(PREFETCH_CYCLES - 1)) begin
          state_nxt = SEND;
          enc_start = 1'b1;
          enc_bit   = word[23];
          pix_start = 1'b1;
        end
      end
      SEND: begin
        if (bit_done) begin
          if (bit_idx != 5'd23) begin
            enc_start = 1'b1;
          end else if (pix != 8'(NUM_LEDS - 1)) begin
            enc_start = 1'b1;
            enc_bit   = word[23];
            pix_start = 1'b1;
          end else begin
            state_nxt = LATCH;
          end
        end
      end
      LATCH: if (frame_done) state_nxt = enable ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      bit_idx  <= '0;
      pix      <= '0;
      sr       <= '0;
      ledindex <= '0;
    end else begin
      if (state_nxt != state)                  cnt <= '0;
      else if (state == LOAD || state == LATCH) cnt <= cnt + CW'(1);

      // ledindex runs one pixel ahead so the colour source has a full pixel time to settle.
      if (pix_start) begin
        sr       <= {word[22:0], 1'b0};
        bit_idx  <= '0;
        pix      <= nxt_pix;
        ledindex <= (nxt_pix == 8'(NUM_LEDS - 1)) ? 8'd0 : nxt_pix + 8'd1;
      end else if (enc_start) begin
        sr       <= {sr[22:0], 1'b0};
        bit_idx  <= bit_idx + 5'd1;
      end
    end
  end

  ws2811_bit_encoder #(
    .BIT_CYCLES (BIT_CYCLES),
    .T0H_CYCLES (T0H_CYCLES),
    .T1H_CYCLES (T1H_CYCLES)
  ) u_enc (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (enc_start),
    .bit_val  (enc_bit),
    .dout     (dout),
    .bit_done (bit_done)
  );

endmodule

// File: tb/tb_ws2811_transmitter.sv
// Directed bench: 2 LEDs, 10-cycle bits (3/7 highs), 50-cycle latch, 4-cycle prefetch.
module tb_ws2811_transmitter;

  logic       clk = 1'b0;
  logic       rst_n, enable;
  logic [7:0] red, green, blue, ledindex;
  logic       dout, busy, frame_done;
  logic [7:0] r0, g0, b0, r1, g1, b1;

  int total = 0;
  int bad   = 0;

  logic       d_tr  [0:1099];
  logic       fd_tr [0:1099];
  logic       bz_tr [0:1099];
  logic [7:0] li_tr [0:1099];

  always #5 clk = ~clk;

  assign red   = (ledindex == 8'd1) ? r1 : r0;
  assign green = (ledindex == 8'd1) ? g1 : g0;
  assign blue  = (ledindex == 8'd1) ? b1 : b0;

  ws2811_transmitter #(
    .NUM_LEDS        (2),
    .BIT_CYCLES      (10),
    .T0H_CYCLES      (3),
    .T1H_CYCLES      (7),
    .RESET_CYCLES    (50),
    .PREFETCH_CYCLES (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .ledindex   (ledindex),
    .dout       (dout),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input int n);
    for (int k = 0; k < n; k++) begin
      d_tr[k]  = dout;
      fd_tr[k] = frame_done;
      bz_tr[k] = busy;
      li_tr[k] = ledindex;
      step();
    end
  endtask

  // Steps until dout first rises; n = edges taken (-1 on timeout), lerr = LOAD cycles that looked wrong.
  task automatic load_phase(output int n, output int lerr, input bit drop_en);
    n = -1;
    lerr = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (drop_en) enable = 1'b0;
      if (dout === 1'b1) begin
        n = i;
        break;
      end
      if (ledindex !== 8'd0 || busy !== 1'b1) lerr++;
    end
  endtask

  function automatic logic [23:0] exp_word(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
`ifdef WS2811_GRB_EN
    return {g, r, b};
`else
    return {r, g, b};
`endif
  endfunction

  function automatic int bit_errs(input int base, input logic bv);
    int e = 0;
    for (int j = 0; j < 10; j++)
      if (d_tr[base + j] !== ((j < (bv ? 7 : 3)) ? 1'b1 : 1'b0)) e++;
    return e;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0;
    #12;
    total++; if (dout !== 1'b0)       begin bad++; $display("FAIL reset_dout got=%b want=0", dout); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (ledindex !== 8'd0)   begin bad++; $display("FAIL reset_ledindex got=%0d want=0", ledindex); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
    step(); rst_n = 1'b1;
    repeat (10) step();
    total++; if (busy !== 1'b0 || dout !== 1'b0) begin
      bad++; $display("FAIL idle_no_enable busy=%b dout=%b want 0/0", busy, dout);
    end
  endtask

  task automatic test_single_frame();
    int n, lerr, ones, fds;
    logic [23:0] w;
    r0 = 8'hFF; g0 = 8'h00; b0 = 8'hAA;
    r1 = 8'hFF; g1 = 8'h00; b1 = 8'hAA;
    enable = 1'b1;
    load_phase(n, lerr, 1'b1);
    total++; if (n != 5)    begin bad++; $display("FAIL sf_load_len got=%0d want=5", n); end
    total++; if (lerr != 0) begin bad++; $display("FAIL sf_load_state bad_cycles=%0d want=0", lerr); end
    capture(540);
    w = exp_word(8'hFF, 8'h00, 8'hAA);
    for (int p = 0; p < 2; p++)
      for (int b = 0; b < 24; b++) begin
        total++;
        if (bit_errs((p * 24 + b) * 10, w[23 - b]) != 0) begin
          bad++; $display("FAIL sf_bit p%0d b%0d err_cycles=%0d want=0 bit=%b", p, b,
                          bit_errs((p * 24 + b) * 10, w[23 - b]), w[23 - b]);
        end
      end
    total++; if (li_tr[0] !== 8'd1)   begin bad++; $display("FAIL sf_ledindex_k0 got=%0d want=1", li_tr[0]); end
    total++; if (li_tr[239] !== 8'd1) begin bad++; $display("FAIL sf_ledindex_k239 got=%0d want=1", li_tr[239]); end
    total++; if (li_tr[240] !== 8'd0) begin bad++; $display("FAIL sf_ledindex_k240 got=%0d want=0", li_tr[240]); end
    fds = 0; ones = 0;
    for (int k = 0; k < 540; k++) begin
      if (fd_tr[k] === 1'b1) fds++;
      if (k >= 480 && d_tr[k] !== 1'b0) ones++;
    end
    total++; if (fd_tr[529] !== 1'b1) begin bad++; $display("FAIL sf_frame_done_k529 got=%b want=1", fd_tr[529]); end
    total++; if (fds != 1)  begin bad++; $display("FAIL sf_frame_done_count got=%0d want=1", fds); end
    total++; if (ones != 0) begin bad++; $display("FAIL sf_latch_low high_cycles=%0d want=0", ones); end
    total++; if (bz_tr[529] !== 1'b1 || bz_tr[530] !== 1'b0) begin
      bad++; $display("FAIL sf_busy_end k529=%b k530=%b want 1/0", bz_tr[529], bz_tr[530]);
    end
  endtask

  task automatic test_back_to_back();
    int n, lerr, fds, lowb, busy_lo;
    logic [23:0] w0, w1;
    r0 = 8'h12; g0 = 8'h34; b0 = 8'h56;
    r1 = 8'hA5; g1 = 8'h0F; b1 = 8'hF0;
    w0 = exp_word(8'h12, 8'h34, 8'h56);
    w1 = exp_word(8'hA5, 8'h0F, 8'hF0);
    enable = 1'b1;
    load_phase(n, lerr, 1'b0);
    total++; if (n != 5) begin bad++; $display("FAIL b2b_load_len got=%0d want=5", n); end
    capture(1100);
    for (int f = 0; f < 2; f++)
      for (int p = 0; p < 2; p++)
        for (int b = 0; b < 24; b++) begin
          total++;
          if (bit_errs(f * 534 + (p * 24 + b) * 10, (p == 0) ? w0[23 - b] : w1[23 - b]) != 0) begin
            bad++; $display("FAIL b2b_bit f%0d p%0d b%0d got_wrong_shape want_bit=%b", f, p, b,
                            (p == 0) ? w0[23 - b] : w1[23 - b]);
          end
        end
    fds = 0; lowb = 0;
    for (int k = 0; k < 1100; k++) begin
      if (fd_tr[k] === 1'b1) fds++;
      if (k < 1064 && bz_tr[k] !== 1'b1) lowb++;
    end
    total++; if (fd_tr[529] !== 1'b1 || fd_tr[1063] !== 1'b1) begin
      bad++; $display("FAIL b2b_frame_done k529=%b k1063=%b want 1/1", fd_tr[529], fd_tr[1063]);
    end
    total++; if (fds != 2)  begin bad++; $display("FAIL b2b_frame_done_count got=%0d want=2", fds); end
    total++; if (lowb != 0) begin bad++; $display("FAIL b2b_busy_drop low_cycles=%0d want=0", lowb); end
    total++; if (li_tr[530] !== 8'd0 || d_tr[533] !== 1'b0 || d_tr[534] !== 1'b1) begin
      bad++; $display("FAIL b2b_restart li530=%0d d533=%b d534=%b want 0/0/1", li_tr[530], d_tr[533], d_tr[534]);
    end
    enable = 1'b0;
    busy_lo = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (busy === 1'b0) begin busy_lo = 1; break; end
    end
    total++; if (busy_lo != 1) begin bad++; $display("FAIL b2b_stop busy still=%b want=0", busy); end
  endtask

  task automatic test_reset_mid_bit();
    int n, lerr, busy_lo;
    r0 = 8'hFF; g0 = 8'h00; b0 = 8'hAA;
    r1 = 8'hFF; g1 = 8'h00; b1 = 8'hAA;
    enable = 1'b1;
    load_phase(n, lerr, 1'b0);
    repeat (52) step();
    total++; if (dout !== 1'b1) begin bad++; $display("FAIL rst_pre_high got=%b want=1", dout); end
    rst_n = 1'b0;
    #1;
    total++; if (dout !== 1'b0)       begin bad++; $display("FAIL rst_mid_dout got=%b want=0", dout); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
    total++; if (ledindex !== 8'd0)   begin bad++; $display("FAIL rst_mid_ledindex got=%0d want=0", ledindex); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_mid_frame_done got=%b want=0", frame_done); end
    step(); step();
    rst_n = 1'b1;
    load_phase(n, lerr, 1'b0);
    total++; if (n != 5)    begin bad++; $display("FAIL rst_restart_load got=%0d want=5", n); end
    total++; if (lerr != 0) begin bad++; $display("FAIL rst_restart_state bad_cycles=%0d want=0", lerr); end
    enable = 1'b0;
    busy_lo = 0;
    for (int i = 0; i < 700; i++) begin
      step();
      if (busy === 1'b0) begin busy_lo = 1; break; end
    end
    total++; if (busy_lo != 1) begin bad++; $display("FAIL rst_finish busy still=%b want=0", busy); end
  endtask

  initial begin
    r0 = '0; g0 = '0; b0 = '0; r1 = '0; g1 = '0; b1 = '0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_reset_mid_bit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
